// File: rtl/multicycle_control_unit_if.sv
// Control/handshake bundle between the multi-cycle control unit and its datapath/memories.
// master = control unit side, slave = datapath/memory side.
interface multicycle_control_unit_if #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 2,
  parameter int unsigned CNT_W    = 16
);
  logic [OPCODE_W-1:0] OPCode;
  logic                InstrReady;
  logic                MemReady;
  logic                Stall;
  logic                IFetch;
  logic                IRWrite;
  logic                PCWrite;
  logic                RegDst;
  logic                ALUSrc;
  logic                MemToReg;
  logic                RegWrite;
  logic                MemRead;
  logic                MemWrite;
  logic [ALUOP_W-1:0]  ALUOp;
  logic                Branch;
  logic                IllegalOp;
  logic                BusError;
  logic [2:0]          StateOut;
  logic [CNT_W-1:0]    RetiredCount;

  modport master (
    input  OPCode, InstrReady, MemReady, Stall,
    output IFetch, IRWrite, PCWrite, RegDst, ALUSrc, MemToReg, RegWrite,
           MemRead, MemWrite, ALUOp, Branch, IllegalOp, BusError, StateOut, RetiredCount
  );

  modport slave (
    output OPCode, InstrReady, MemReady, Stall,
    input  IFetch, IRWrite, PCWrite, RegDst, ALUSrc, MemToReg, RegWrite,
           MemRead, MemWrite, ALUOp, Branch, IllegalOp, BusError, StateOut, RetiredCount
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the 16-bit CPU with
// ready handshakes, stall, ready timeout, illegal-opcode detection and a retire counter.
module multicycle_control_unit #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 2,
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned TO_W     = 4,
  parameter int unsigned CNT_W    = 16
) (
  input logic                  Clock,
  input logic                  Reset_n,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4
  } ctrlStateT;

  ctrlStateT        state, nextState;
  logic [3:0]       opReg, opNext;
  logic [TO_W-1:0]  toCnt, toNext;
  logic [CNT_W-1:0] retiredCnt;
  logic             resetHold;
  logic             retire;
  logic             isR, isI, isLw, isSw, isBeq, opLegal;
  logic             ready, inWait, timedOut;

  // Opcode classes of the latched instruction; legality is judged on the live opcode in DECODE.
  assign isR     = opReg inside {4'b0000, 4'b0001, 4'b0010};
  assign isI     = opReg inside {4'b1001, 4'b1010, 4'b1011};
  assign isLw    = (opReg == 4'b1100);
  assign isSw    = (opReg == 4'b1101);
  assign isBeq   = (opReg == 4'b1111);
  assign opLegal = ((bus.OPCode >> 4) == '0) &&
                   (bus.OPCode[3:0] inside {4'b0000, 4'b0001, 4'b0010, 4'b1001, 4'b1010,
                                            4'b1011, 4'b1100, 4'b1101, 4'b1111});

  assign ready    = (state == MEM) ? bus.MemReady : bus.InstrReady;
  assign inWait   = (state == FETCH) || (state == MEM);
  assign timedOut = inWait && !ready && (toCnt == TO_W'(TIMEOUT));

  assign bus.StateOut     = state;
  assign bus.RetiredCount = retiredCnt;

  // resetHold keeps every output quiet for the cycle following a reset edge.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state      <= FETCH;
      opReg      <= '0;
      toCnt      <= '0;
      retiredCnt <= '0;
      resetHold  <= 1'b1;
    end else begin
      state     <= nextState;
      opReg     <= opNext;
      toCnt     <= toNext;
      resetHold <= 1'b0;
      if (retire) retiredCnt <= retiredCnt + CNT_W'(1);
    end
  end

  always_comb begin
    nextState     = state;
    opNext        = opReg;
    toNext        = toCnt;
    retire        = 1'b0;
    bus.IFetch    = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.RegDst    = 1'b0;
    bus.ALUSrc    = 1'b0;
    bus.MemToReg  = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.ALUOp     = '0;
    bus.Branch    = 1'b0;
    bus.IllegalOp = 1'b0;
    bus.BusError  = 1'b0;

    if (Reset_n && !resetHold) begin
      case (state)
        FETCH: begin
          bus.IFetch = 1'b1;
          if (!bus.Stall) begin
            if (bus.InstrReady) begin
              bus.IRWrite = 1'b1;
              bus.PCWrite = 1'b1;
              nextState   = DECODE;
            end else if (timedOut) begin
              bus.BusError = 1'b1;
            end
          end
        end
        DECODE: begin
          if (!bus.Stall) begin
            opNext = bus.OPCode[3:0];
            if (opLegal) begin
              nextState = EXECUTE;
            end else begin
              bus.IllegalOp = 1'b1;
              nextState     = FETCH;
            end
          end
        end
        EXECUTE: begin
          if (isR) begin
            bus.RegDst = 1'b1;
            bus.ALUOp  = ALUOP_W'(2'b10);
          end else if (isI) begin
            bus.ALUSrc = 1'b1;
            bus.ALUOp  = ALUOP_W'(2'b11);
          end else if (isLw || isSw) begin
            bus.ALUSrc = 1'b1;
          end else if (isBeq) begin
            bus.ALUOp  = ALUOP_W'(2'b01);
            bus.Branch = 1'b1;
          end
          if (!bus.Stall) begin
            if (isBeq) begin
              nextState = FETCH;
              retire    = 1'b1;
            end else if (isLw || isSw) begin
              nextState = MEM;
            end else begin
              nextState = WRITEBACK;
            end
          end
        end
        MEM: begin
          bus.MemRead = isLw;
          if (!bus.Stall) begin
            if (bus.MemReady) begin
              bus.MemWrite = isSw;
              nextState    = isLw ? WRITEBACK : FETCH;
              retire       = isSw;
            end else if (timedOut) begin
              bus.BusError = 1'b1;
              nextState    = FETCH;
            end else begin
              bus.MemWrite = isSw;
            end
          end
        end
        WRITEBACK: begin
          bus.RegDst   = isR;
          bus.MemToReg = isLw;
          bus.RegWrite = !bus.Stall;
          if (!bus.Stall) begin
            nextState = FETCH;
            retire    = 1'b1;
          end
        end
        default: nextState = FETCH;
      endcase

      // Wait counter runs only while a handshake is outstanding; any exit or timeout clears it.
      if (!bus.Stall) toNext = (inWait && !ready && !timedOut) ? toCnt + TO_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed scenarios then random stimulus, each cycle
// checked against an instruction-level reference model; two DUTs cover both counter widths.
module tb_multicycle_control_unit;

  localparam int unsigned TIMEOUT = 15;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       stall = 1'b0;
  logic [3:0] opc = 4'd0;
  logic       ir = 1'b0;
  logic       mr = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference model state: pipeline phase, latched opcode, cycles waited, instructions retired.
  int         stage = 0;
  int         waited = 0;
  int         retired = 0;
  logic [3:0] mOp = 4'd0;
  bit         quiet = 1'b1;

  always #5 Clock = ~Clock;

  multicycle_control_unit_if #(.OPCODE_W(4), .ALUOP_W(2), .CNT_W(16)) busA ();
  multicycle_control_unit_if #(.OPCODE_W(4), .ALUOP_W(3), .CNT_W(2))  busB ();

  assign busA.OPCode = opc;
  assign busA.InstrReady = ir;
  assign busA.MemReady = mr;
  assign busA.Stall = stall;
  assign busB.OPCode = opc;
  assign busB.InstrReady = ir;
  assign busB.MemReady = mr;
  assign busB.Stall = stall;

  multicycle_control_unit #(.OPCODE_W(4), .ALUOP_W(2), .TIMEOUT(TIMEOUT), .TO_W(4), .CNT_W(16)) dutA (
    .Clock(Clock), .Reset_n(Reset_n), .bus(busA));
  multicycle_control_unit #(.OPCODE_W(4), .ALUOP_W(3), .TIMEOUT(TIMEOUT), .TO_W(4), .CNT_W(2)) dutB (
    .Clock(Clock), .Reset_n(Reset_n), .bus(busB));

  task automatic checkVal(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // 0 illegal, 1 R-type, 2 I-type, 3 LW, 4 SW, 5 BEQ
  function automatic int opClass(input logic [3:0] o);
    case (o)
      4'd0, 4'd1, 4'd2:   return 1;
      4'd9, 4'd10, 4'd11: return 2;
      4'd12:              return 3;
      4'd13:              return 4;
      4'd15:              return 5;
      default:            return 0;
    endcase
  endfunction

  task automatic step(input bit rst, input bit st, input logic [3:0] o, input bit i, input bit m,
                      input bit doCheck);
    bit eIF, eIR, ePC, eRD, eAS, eMTR, eRW, eMR, eMW, eBR, eIL, eBE, ret, rdy, tout, waiting;
    int eAO, nxt, cls;
    logic [17:0] expV, gotA, gotB;
    @(negedge Clock);
    Reset_n = rst; stall = st; opc = o; ir = i; mr = m;
    #1;
    {eIF, eIR, ePC, eRD, eAS, eMTR, eRW, eMR, eMW, eBR, eIL, eBE, ret} = '0;
    eAO = 0;
    nxt = stage;
    cls = opClass(mOp);
    waiting = (stage == 0) || (stage == 3);
    rdy = (stage == 3) ? m : i;
    tout = waiting && !rdy && (waited == TIMEOUT);
    if (rst && !quiet) begin
      case (stage)
        0: begin
          eIF = 1'b1;
          if (!st && i) begin eIR = 1'b1; ePC = 1'b1; nxt = 1; end
          else if (!st && tout) eBE = 1'b1;
        end
        1: if (!st) begin
          if (opClass(o) == 0) begin eIL = 1'b1; nxt = 0; end
          else nxt = 2;
        end
        2: begin
          if (cls == 1) begin eRD = 1'b1; eAO = 2; end
          if (cls == 2) begin eAS = 1'b1; eAO = 3; end
          if (cls == 3 || cls == 4) eAS = 1'b1;
          if (cls == 5) begin eAO = 1; eBR = 1'b1; end
          if (!st) begin
            nxt = (cls == 5) ? 0 : (cls == 3 || cls == 4) ? 3 : 4;
            ret = (cls == 5);
          end
        end
        3: begin
          eMR = (cls == 3);
          if (!st && m) begin eMW = (cls == 4); nxt = (cls == 3) ? 4 : 0; ret = (cls == 4); end
          else if (!st && tout) begin eBE = 1'b1; nxt = 0; end
          else if (!st) eMW = (cls == 4);
        end
        4: begin
          eMTR = (cls == 3); eRD = (cls == 1); eRW = !st;
          if (!st) begin nxt = 0; ret = 1'b1; end
        end
        default: nxt = 0;
      endcase
    end
    expV = {eIF, eIR, ePC, eRD, eAS, eMTR, eRW, eMR, eMW, eBR, eIL, eBE, 3'(eAO), 3'(stage)};
    gotA = {busA.IFetch, busA.IRWrite, busA.PCWrite, busA.RegDst, busA.ALUSrc, busA.MemToReg,
            busA.RegWrite, busA.MemRead, busA.MemWrite, busA.Branch, busA.IllegalOp, busA.BusError,
            1'b0, busA.ALUOp, busA.StateOut};
    gotB = {busB.IFetch, busB.IRWrite, busB.PCWrite, busB.RegDst, busB.ALUSrc, busB.MemToReg,
            busB.RegWrite, busB.MemRead, busB.MemWrite, busB.Branch, busB.IllegalOp, busB.BusError,
            busB.ALUOp, busB.StateOut};
    if (doCheck) begin
      checkVal("ctlA", 32'(gotA), 32'(expV));
      checkVal("ctlB", 32'(gotB), 32'(expV));
      checkVal("retiredA", 32'(busA.RetiredCount), 32'(retired) & 32'hFFFF);
      checkVal("retiredB", 32'(busB.RetiredCount), 32'(retired) & 32'h3);
    end
    if (!rst) begin
      stage = 0; waited = 0; retired = 0; mOp = 4'd0; quiet = 1'b1;
    end else if (quiet) begin
      quiet = 1'b0;
    end else if (!st) begin
      if (stage == 1) mOp = o;
      waited = (nxt != stage || tout || !waiting) ? 0 : waited + 1;
      stage = nxt;
      if (ret) retired++;
    end
  endtask

  initial begin
    bit slow, ri, rm;
    // Reset held with Stall=1; first cycle has an unknown pre-reset state so it is not checked.
    step(0, 1, 4'd0, 0, 0, 0);
    step(0, 1, 4'd0, 0, 0, 1);
    step(1, 0, 4'd0, 1, 0, 1);
    // ADD with immediate ready: FETCH, DECODE, EXECUTE, WRITEBACK
    repeat (4) step(1, 0, 4'd1, 1, 0, 1);
    // LW, MemReady after 3 waiting MEM cycles
    repeat (3) step(1, 0, 4'd12, 1, 0, 1);
    repeat (3) step(1, 0, 4'd12, 1, 0, 1);
    repeat (2) step(1, 0, 4'd12, 1, 1, 1);
    // SW with 2-cycle stall in MEM while MemReady is already high
    repeat (3) step(1, 0, 4'd13, 1, 1, 1);
    repeat (2) step(1, 1, 4'd13, 1, 1, 1);
    step(1, 0, 4'd13, 1, 1, 1);
    // Illegal opcode then BEQ
    repeat (2) step(1, 0, 4'd7, 1, 0, 1);
    repeat (3) step(1, 0, 4'd15, 1, 0, 1);
    // FETCH timeout: BusError in the 16th waiting cycle, then a fresh wait
    repeat (18) step(1, 0, 4'd15, 0, 0, 1);
    // Four BEQs walk the 2-bit counter through wrap
    repeat (12) step(1, 0, 4'd15, 1, 0, 1);
    // Random traffic with bursts of slow memory to provoke timeouts
    slow = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) slow = ($urandom_range(0, 3) == 0);
      ri = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0);
      rm = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0);
      step($urandom_range(0, 299) != 0, $urandom_range(0, 5) == 0,
           4'($urandom_range(0, 15)), ri, rm, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle successor of the single-cycle opcode decoder in the 16-bit CPU.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Holds the datapath control lines stable per state, and handshakes with instruction and data memory using ready signals.
- Adds stall, memory timeout, illegal-opcode detection and a retired-instruction counter.

Parameters:
- OPCODE_W, 4, opcode width (≥4). Bits above [3:0] must be zero, otherwise the opcode is illegal.
- ALUOP_W, 2, ALUOp width (≥2). Upper bits are driven 0.
- TIMEOUT, 15, maximum wait cycles on a ready signal before BusError (1..2^TO_W-1).
- TO_W, 4, timeout counter width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- Clock input 1: rising-edge clock.
- Reset_n input 1: synchronous, active-low reset.
- OPCode input OPCODE_W: opcode field of the instruction; sampled in DECODE.
- InstrReady input 1: instruction memory has data this cycle.
- MemReady input 1: data memory has completed the access this cycle.
- Stall input 1: freeze the FSM; suppress all strobes.
- IFetch output 1: instruction fetch request.
- IRWrite output 1: load the instruction register.
- PCWrite output 1: PC+2 update.
- RegDst output 1: destination register select.
- ALUSrc output 1: ALU operand B select.
- MemToReg output 1: write-back source select.
- RegWrite output 1: register file write strobe.
- MemRead output 1: data memory read request.
- MemWrite output 1: data memory write request.
- ALUOp output ALUOP_W: ALU operation class.
- Branch output 1: BEQ branch qualify.
- IllegalOp output 1: one-cycle pulse on an undefined opcode.
- BusError output 1: one-cycle pulse on a ready timeout.
- StateOut output 3: current state encoding.
- RetiredCount output CNT_W: completed-instruction count.

Behaviour:
- **State encoding:** FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4. Codes 5–7 are unreachable and return to FETCH.
- **Reset:** Reset_n=0 at a clock edge forces the following on the next cycle, regardless of Stall:
  - state FETCH;
  - all outputs 0;
  - opcode register 0;
  - timeout counter 0;
  - RetiredCount 0.
- **Reset mid-access:** reset during MEM or FETCH aborts the access. No strobe is issued.
- **Output decode:** all control outputs decode combinationally from the state and the latched opcode. Strobes are additionally gated by ~Stall.
- **FETCH:**
  - IFetch=1 held until InstrReady=1.
  - In the ready cycle, IRWrite=1 and PCWrite=1 for that single cycle, then go to DECODE.
- **DECODE:**
  - Latch OPCode.
  - If illegal: IllegalOp=1 for this cycle, go to FETCH, no count. Legal opcodes are 0000, 0001, 0010, 1001, 1010, 1011, 1100, 1101, 1111.
  - If legal, go to EXECUTE.
- **EXECUTE:** ALU controls are valid this cycle. Per opcode class:
  - R-type (0000/0001/0010): RegDst=1, ALUSrc=0, ALUOp=10.
  - I-type (1001/1010/1011): RegDst=0, ALUSrc=1, ALUOp=11.
  - LW/SW: ALUSrc=1, ALUOp=00.
  - BEQ: ALUSrc=0, ALUOp=01, Branch=1.
  - Shift opcodes drive ALUSrc=0; no X is ever output.
- **EXECUTE next state:** R/I-type go to WRITEBACK. LW/SW go to MEM. BEQ goes to FETCH and counts as retired.
- **MEM:**
  - LW holds MemRead=1; SW holds MemWrite=1, until MemReady=1.
  - On ready, LW goes to WRITEBACK. SW goes to FETCH and counts as retired.
- **WRITEBACK:**
  - RegWrite=1 for exactly one cycle.
  - MemToReg=1 for LW, otherwise 0. RegDst holds its EXECUTE value.
  - Then go to FETCH and count as retired.
- **Timeout:**
  - The counter increments each non-stalled cycle in FETCH/MEM while ready=0, and clears on a state change.
  - When the counter reaches TIMEOUT with ready still 0: BusError=1 for one cycle, go to FETCH, no count, no strobes.
  - If ready=1 in the TIMEOUT cycle, ready wins.
- **Stall:**
  - The state, opcode register and timeout counter hold.
  - IRWrite, PCWrite, RegWrite and MemWrite are forced to 0. IllegalOp and BusError are suppressed, and re-evaluate after the stall.
  - Level outputs are unchanged: IFetch, MemRead, RegDst, ALUSrc, MemToReg, ALUOp, Branch.
  - A ready signal arriving while Stall=1 is ignored; the memory must hold ready until it is accepted.
- **RetiredCount:** increments by 1 on each retire and wraps at 2^CNT_W-1 → 0.
- **Latency (no stalls, ready immediate):**
  - R/I-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - Illegal: 2 cycles.

Test Plan:
1. **Reset with stall:** Reset_n=0 for 2 cycles while Stall=1 → StateOut=0, all outputs 0, RetiredCount=0 after the first edge.
2. **ADD, immediate ready:** OPCode=0001, InstrReady=1 → states 0,1,2,4,0. In EXECUTE: RegDst=1, ALUOp=10. WRITEBACK: RegWrite=1 for a single cycle. RetiredCount=1.
3. **LW with delayed MemReady:** OPCode=1100, MemReady asserted 3 cycles into MEM → MemRead=1 for 4 cycles, then WRITEBACK with MemToReg=1, RegWrite=1. RetiredCount increments by 1.
4. **SW with a mid-MEM stall:** OPCode=1101; Stall=1 for 2 cycles in MEM while MemReady=1 → MemWrite=0 during the stall, 1 after. Exit on the first non-stalled ready cycle.
5. **Illegal opcode and BEQ:** OPCode=0111 → IllegalOp pulse in DECODE, back to FETCH, RetiredCount unchanged. Then OPCode=1111 → Branch=1, ALUOp=01 in EXECUTE, 3-cycle retire.
6. **Timeout, then wrap:**
   - With TIMEOUT=15, hold InstrReady=0 → BusError pulses in the 16th FETCH cycle, then FETCH restarts.
   - With CNT_W=2, 4 BEQs → RetiredCount sequence 1, 2, 3, 0.
